// File: rtl/synth_pkg.sv
// Types and constants shared by the keyboard allocator and the voice mixer.
// Voice state widths and the output saturation helper live here.
package synth_pkg;

    localparam int unsigned NUM_VOICES  = 8;
    localparam int unsigned FULL_VOLUME = 1 << 20;
    localparam int unsigned ENV_W       = 21;
    localparam int unsigned ACC_W       = 19;

    typedef shortint                 freq_t;
    typedef int                      volume_t;
    typedef logic signed [15:0]      sample_t;
    typedef logic [ENV_W-1:0]        env_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StOut
    } mix_state_e;

    localparam acc_t SAT_MAX = acc_t'(32767);
    localparam acc_t SAT_MIN = acc_t'(-32768);

    function automatic sample_t saturate16(input acc_t value);
        if (value > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (value < SAT_MIN) begin
            return 16'sh8000;
        end
        return value[15:0];
    endfunction

endpackage

// File: rtl/synth_voice_datapath.sv
// One voice step: envelope slew toward the clamped target, phase advance,
// sawtooth oscillator and envelope-scaled contribution. Purely combinational.
module synth_voice_datapath
    import synth_pkg::*;
#(
    parameter int unsigned PHASE_INC_MUL = 2749,
    parameter int unsigned ATTACK_STEP   = 1024,
    parameter int unsigned RELEASE_STEP  = 256
) (
    input  logic [31:0] i_phase,
    input  env_t        i_env,
    input  logic [15:0] i_freq,
    input  volume_t     i_volume,
    output logic [31:0] o_phase,
    output env_t        o_env,
    output sample_t     o_contrib
);

    localparam env_t        Full    = env_t'(FULL_VOLUME);
    localparam env_t        Attack  = env_t'(ATTACK_STEP);
    localparam env_t        Release = env_t'(RELEASE_STEP);
    localparam logic [31:0] IncMul  = 32'(PHASE_INC_MUL);

    env_t                w_target;
    env_t                w_env;
    logic [31:0]         w_inc;
    logic [31:0]         w_phase_sum;
    logic [31:0]         w_phase;
    sample_t             w_saw;
    logic signed [30:0]  w_saw_ext;
    logic signed [30:0]  w_env_ext;
    logic signed [30:0]  w_prod;
    logic                unused_prod_lsbs;

    always_comb begin
        w_target = '0;
        if (i_volume[31]) begin
            w_target = '0;
        end else if (i_volume > volume_t'(FULL_VOLUME)) begin
            w_target = Full;
        end else begin
            w_target = i_volume[ENV_W-1:0];
        end
    end

    // Step toward the target but never past it.
    always_comb begin
        w_env = i_env;
        if (i_env < w_target) begin
            if (w_target - i_env > Attack) begin
                w_env = i_env + Attack;
            end else begin
                w_env = w_target;
            end
        end else if (i_env > w_target) begin
            if (i_env - w_target > Release) begin
                w_env = i_env - Release;
            end else begin
                w_env = w_target;
            end
        end
    end

    assign w_inc       = {16'b0, i_freq} * IncMul;
    assign w_phase_sum = i_phase + w_inc;
    // A silent, idle voice is held at phase 0 so the next note starts cleanly.
    assign w_phase     = (w_env == '0 && w_target == '0) ? '0 : w_phase_sum;

    assign w_saw     = sample_t'(w_phase[31:16] ^ 16'h8000);
    assign w_saw_ext = {{15{w_saw[15]}}, w_saw};
    assign w_env_ext = {15'b0, w_env[20:5]};
    assign w_prod    = w_saw_ext * w_env_ext;

    assign o_phase          = w_phase;
    assign o_env            = w_env;
    assign o_contrib        = w_prod[30:15];
    assign unused_prod_lsbs = ^w_prod[14:0];

endmodule

// File: rtl/synth_voice_mixer.sv
// Eight-voice oscillator/envelope/mixer: one shared datapath visits every voice
// once per sample period and the sum is shifted, saturated and strobed out.
module synth_voice_mixer
    import synth_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 1024,
    parameter int unsigned PHASE_INC_MUL = 2749,
    parameter int unsigned ATTACK_STEP   = 1024,
    parameter int unsigned RELEASE_STEP  = 256,
    parameter int unsigned MIX_SHIFT     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] frequencies   [NUM_VOICES],
    input  volume_t     voice_volumes [NUM_VOICES],
    output sample_t     audio_out,
    output logic        sample_valid
);

    localparam int unsigned    DivW    = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [2:0]      LastVoice = 3'(NUM_VOICES - 1);

    logic [DivW-1:0] r_div;
    mix_state_e      r_state;
    mix_state_e      w_state_next;
    logic [2:0]      r_voice;
    logic [31:0]     r_phase [NUM_VOICES];
    env_t            r_env   [NUM_VOICES];
    acc_t            r_acc;
    sample_t         r_audio;
    logic            r_valid;

    logic            w_tick;
    logic            w_last_voice;
    logic [31:0]     w_phase_next;
    env_t            w_env_next;
    sample_t         w_contrib;
    acc_t            w_contrib_ext;
    acc_t            w_acc_next;
    acc_t            w_acc_shift;

    assign w_tick       = (r_div == DivLast);
    assign w_last_voice = (r_voice == LastVoice);

    synth_voice_datapath #(
        .PHASE_INC_MUL (PHASE_INC_MUL),
        .ATTACK_STEP   (ATTACK_STEP),
        .RELEASE_STEP  (RELEASE_STEP)
    ) u_datapath (
        .i_phase   (r_phase[r_voice]),
        .i_env     (r_env[r_voice]),
        .i_freq    (frequencies[r_voice]),
        .i_volume  (voice_volumes[r_voice]),
        .o_phase   (w_phase_next),
        .o_env     (w_env_next),
        .o_contrib (w_contrib)
    );

    assign w_contrib_ext = {{(ACC_W - 16){w_contrib[15]}}, w_contrib};
    assign w_acc_next    = r_acc + w_contrib_ext;
    assign w_acc_shift   = w_acc_next >>> MIX_SHIFT;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_tick) w_state_next = StRun;
            StRun:   if (w_last_voice) w_state_next = StOut;
            StOut:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_voice <= '0;
            r_acc   <= '0;
            r_audio <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
                r_env[i]   <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_tick) begin
                        r_acc   <= '0;
                        r_voice <= '0;
                    end
                end
                StRun: begin
                    r_phase[r_voice] <= w_phase_next;
                    r_env[r_voice]   <= w_env_next;
                    r_acc            <= w_acc_next;
                    r_voice          <= r_voice + 1'b1;
                    // Output registers load with the last voice, so they are live during OUT.
                    if (w_last_voice) begin
                        r_audio <= saturate16(w_acc_shift);
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign audio_out    = r_audio;
    assign sample_valid = r_valid;

endmodule
